// File: rtl/rr_arb_4.sv
// rr_arb_4: 4-way round-robin arbiter with per-grant hold limit; optional lock input via ARB_LOCK_EN
module rr_arb_4 #(
   parameter int HOLD_MAX = 8,
   parameter int CNT_W = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       en,
`ifdef ARB_LOCK_EN
   input  logic       lock,
`endif
   input  logic [3:0] req,
   output logic [3:0] gnt,
   output logic [1:0] gnt_idx,
   output logic       gnt_vld
);
   typedef enum logic {IDLE, GRANT} state_t;
   state_t state, state_nx;
   logic [CNT_W-1:0] hold_cnt, cnt_nx;
   logic [1:0] last, last_nx, idx_nx, win, cand;
   logic [3:0] mask;
   logic found, grant, at_max, expire, hold_lock;
`ifdef ARB_LOCK_EN
   assign hold_lock = lock;
`else
   assign hold_lock = 1'b0;
`endif
   assign at_max = (HOLD_MAX != 0) && (hold_cnt == CNT_W'(HOLD_MAX - 1));
   assign expire = at_max && !hold_lock;
   assign mask = (state == GRANT) ? req & ~(4'b0001 << gnt_idx) : req;
   // rotating search: first set mask bit starting just after the last grant
   always_comb begin
      win = 2'd0;
      found = 1'b0;
      cand = 2'd0;
      for (int k = 0; k < 4; k++) begin
         cand = 2'(last + 2'(k + 1));
         if (!found && mask[cand]) begin
            win = cand;
            found = 1'b1;
         end
      end
   end
   // next state: revoke, release/expiry handoff, re-grant or keep counting
   always_comb begin
      state_nx = state;
      idx_nx = gnt_idx;
      last_nx = last;
      cnt_nx = hold_cnt;
      grant = 1'b0;
      if (state == IDLE) grant = en && found;
      else if (!en) state_nx = IDLE;
      else if (!req[gnt_idx] || expire) begin
         if (found) grant = 1'b1;
         else if (req[gnt_idx]) cnt_nx = '0;
         else state_nx = IDLE;
      end else cnt_nx = at_max ? hold_cnt : hold_cnt + 1'b1;
      if (grant) begin
         state_nx = GRANT;
         idx_nx = win;
         last_nx = win;
         cnt_nx = '0;
      end
   end
   // state and registered grant outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         gnt_idx <= 2'd0;
         gnt_vld <= 1'b0;
         gnt <= 4'b0000;
         hold_cnt <= '0;
         last <= 2'd3;
      end else begin
         state <= state_nx;
         gnt_idx <= idx_nx;
         gnt_vld <= state_nx == GRANT;
         gnt <= (state_nx == GRANT) ? 4'b0001 << idx_nx : 4'b0000;
         hold_cnt <= cnt_nx;
         last <= last_nx;
      end
   end
endmodule

// File: tb/tb_rr_arb_4.sv
// tb_rr_arb_4: vector table plus hand sequences for rr_arb_4, checked through an expectation queue
module tb_rr_arb_4;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic en = 1'b0;
   logic [3:0] req = 4'b0000;
`ifdef ARB_LOCK_EN
   logic lock = 1'b0;
`endif
   logic [3:0] gnt;
   logic [1:0] gnt_idx;
   logic gnt_vld;

   typedef struct packed {
      logic       en;
      logic [3:0] req;
      logic [3:0] gnt;
      logic [1:0] idx;
      logic       vld;
   } vec_t;

   vec_t tbl[18];
   logic [6:0] sb_q[$];
   int vectors = 0;
   int miscompares = 0;

   rr_arb_4 dut (
      .clk(clk),
      .rst_n(rst_n),
      .en(en),
`ifdef ARB_LOCK_EN
      .lock(lock),
`endif
      .req(req),
      .gnt(gnt),
      .gnt_idx(gnt_idx),
      .gnt_vld(gnt_vld)
   );

   always #5 clk = ~clk;

   task automatic compare(input string name, input bit strict);
      logic [6:0] e;
      e = sb_q.pop_front();
      vectors++;
      if (gnt !== e[6:3] || gnt_vld !== e[0] || ((e[0] || strict) && gnt_idx !== e[2:1])) begin
         miscompares++;
         $display("FAIL %s: got gnt=%b idx=%0d vld=%b, want gnt=%b idx=%0d vld=%b",
                  name, gnt, gnt_idx, gnt_vld, e[6:3], e[2:1], e[0]);
      end
   endtask

   task automatic apply(input logic e, input logic [3:0] r, input logic [3:0] g,
                        input logic [1:0] i, input logic v, input string name);
      en = e;
      req = r;
      sb_q.push_back({g, i, v});
      @(posedge clk);
      #1;
      compare(name, 1'b0);
   endtask

   initial begin
      tbl = '{
         '{1'b1, 4'b0100, 4'b0100, 2'd2, 1'b1},
         '{1'b1, 4'b0100, 4'b0100, 2'd2, 1'b1},
         '{1'b1, 4'b0100, 4'b0100, 2'd2, 1'b1},
         '{1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0},
         '{1'b1, 4'b0010, 4'b0010, 2'd1, 1'b1},
         '{1'b1, 4'b1010, 4'b0010, 2'd1, 1'b1},
         '{1'b1, 4'b1000, 4'b1000, 2'd3, 1'b1},
         '{1'b1, 4'b1001, 4'b1000, 2'd3, 1'b1},
         '{1'b1, 4'b0001, 4'b0001, 2'd0, 1'b1},
         '{1'b1, 4'b0010, 4'b0010, 2'd1, 1'b1},
         '{1'b0, 4'b0010, 4'b0000, 2'd0, 1'b0},
         '{1'b1, 4'b0110, 4'b0100, 2'd2, 1'b1},
         '{1'b1, 4'b0110, 4'b0100, 2'd2, 1'b1},
         '{1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0},
         '{1'b1, 4'b1011, 4'b1000, 2'd3, 1'b1},
         '{1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0},
         '{1'b0, 4'b1111, 4'b0000, 2'd0, 1'b0},
         '{1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0}
      };
      #2;
      sb_q.push_back({4'b0000, 2'd0, 1'b0});
      compare("reset_state", 1'b1);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      for (int n = 0; n < 18; n++)
         apply(tbl[n].en, tbl[n].req, tbl[n].gnt, tbl[n].idx, tbl[n].vld, $sformatf("tbl%0d", n));
      for (int g = 0; g < 5; g++)
         for (int c = 0; c < 8; c++)
            apply(1'b1, 4'b1111, 4'b0001 << (g % 4), 2'(g % 4), 1'b1, $sformatf("rot_g%0d_c%0d", g, c));
      apply(1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0, "rot_idle");
      for (int c = 0; c < 20; c++)
         apply(1'b1, 4'b0100, 4'b0100, 2'd2, 1'b1, $sformatf("solo_c%0d", c));
      apply(1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0, "solo_idle");
      apply(1'b1, 4'b0010, 4'b0010, 2'd1, 1'b1, "pre_reset");
      #3;
      rst_n = 1'b0;
      #1;
      sb_q.push_back({4'b0000, 2'd0, 1'b0});
      compare("async_reset", 1'b1);
      en = 1'b0;
      req = 4'b0000;
      @(posedge clk);
      #3;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      apply(1'b1, 4'b0110, 4'b0010, 2'd1, 1'b1, "post_reset");
      apply(1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0, "post_idle");
`ifdef ARB_LOCK_EN
      lock = 1'b1;
      for (int c = 0; c < 28; c++)
         apply(1'b1, 4'b0011, 4'b0001, 2'd0, 1'b1, $sformatf("lock_c%0d", c));
      lock = 1'b0;
      apply(1'b1, 4'b0011, 4'b0010, 2'd1, 1'b1, "unlock");
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
